// File: rtl/addsub_serial_if.sv
// Operand/result bundle for addsub_serial.
//   master : drives start/mode/a/b/carry_in, observes busy/done/res/flags
//   slave  : the serial adder/subtractor itself
interface addsub_serial_if #(parameter int WIDTH = 8);
  logic             start;
  logic             mode;       // 0 = add, 1 = subtract
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;   // carry-in (add) / borrow-in (sub)
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] res;
  logic             carry_out;  // carry (add) / borrow (sub) out of MSB
  logic             overflow;
  logic             zero;

  modport master (output start, mode, a, b, carry_in,
                  input  busy, done, res, carry_out, overflow, zero);
  modport slave  (input  start, mode, a, b, carry_in,
                  output busy, done, res, carry_out, overflow, zero);
endinterface

// File: rtl/addsub_serial.sv
// Multi-cycle adder/subtractor: DIGIT bits per cycle over WIDTH-bit operands,
// carry/borrow rippled between steps through a register.
// Ports:
//   clk, rst_n : clock (rising edge), async active-low reset
//   bus        : addsub_serial_if.slave (start/mode/a/b/carry_in in;
//                busy/done/res/carry_out/overflow/zero out)
// Subtraction is a + ~b + ~bin, so one digit cell serves both modes and
// the final carry is inverted to report a borrow.

// One DIGIT-wide ripple cell.
module addsub_digit #(parameter int DIGIT = 1) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
endmodule

module addsub_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic           clk,
  input logic           rst_n,
  addsub_serial_if.slave bus
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             mode_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             carry_q;
  logic             busy_q, done_q, co_q, ov_q, z_q;

  logic [31:0]      base;
  logic [DIGIT-1:0] a_d, b_d, s_d;
  logic             c_d;
  logic [WIDTH-1:0] res_nxt;
  logic             last;
  logic             accept;

  assign base   = 32'(cnt) * 32'(DIGIT);
  assign a_d    = a_q[base +: DIGIT];
  assign b_d    = b_q[base +: DIGIT] ^ {DIGIT{mode_q}};
  assign last   = (cnt == CW'(STEPS - 1));
  assign accept = bus.start && (state == IDLE || state == DONE);

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a(a_d), .b(b_d), .cin(carry_q), .sum(s_d), .cout(c_d)
  );

  // Result with the current digit merged in; flags on the last step see the
  // complete word through this.
  always_comb begin
    res_nxt = res_q;
    res_nxt[base +: DIGIT] = s_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      mode_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      z_q     <= 1'b0;
    end else if (accept) begin
      state   <= RUN;
      cnt     <= '0;
      mode_q  <= bus.mode;
      a_q     <= bus.a;
      b_q     <= bus.b;
      carry_q <= bus.mode ? ~bus.carry_in : bus.carry_in;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          res_q   <= res_nxt;
          carry_q <= c_d;
          cnt     <= cnt + 1'b1;
          if (last) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            co_q   <= mode_q ? ~c_d : c_d;
            // Signed overflow: effective B sign equals A sign, result sign differs.
            ov_q   <= ((a_q[WIDTH-1] ^ b_q[WIDTH-1]) == mode_q) &&
                      (res_nxt[WIDTH-1] != a_q[WIDTH-1]);
            z_q    <= (res_nxt == '0);
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.res       = res_q;
  assign bus.carry_out = co_q;
  assign bus.overflow  = ov_q;
  assign bus.zero      = z_q;
endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: a DIGIT=1 and a DIGIT=4 instance (WIDTH=8),
// expected results from a reference model pushed to a queue at start and
// popped when done is seen.
module tb_addsub_serial;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  addsub_serial_if #(.WIDTH(8)) if1 ();
  addsub_serial_if #(.WIDTH(8)) if4 ();

  addsub_serial #(.WIDTH(8), .DIGIT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  addsub_serial #(.WIDTH(8), .DIGIT(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  typedef struct packed {
    logic [7:0] res;
    logic       co;
    logic       ov;
    logic       z;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t model(input bit m, input logic [7:0] a, input logic [7:0] b,
                                 input logic c);
    exp_t       e;
    logic [8:0] t;
    int         sa, sb_, s;
    sa = $signed(a);
    sb_ = $signed(b);
    if (!m) begin
      t = {1'b0, a} + {1'b0, b} + {8'b0, c};
      s = sa + sb_ + int'(c);
    end else begin
      t = {1'b0, a} - {1'b0, b} - {8'b0, c};
      s = sa - sb_ - int'(c);
    end
    e.res = t[7:0];
    e.co  = t[8];
    e.ov  = (s > 127) || (s < -128);
    e.z   = (t[7:0] == 8'd0);
    return e;
  endfunction

  function automatic exp_t observed(input bit d4);
    exp_t o;
    if (d4) o = '{if4.res, if4.carry_out, if4.overflow, if4.zero};
    else    o = '{if1.res, if1.carry_out, if1.overflow, if1.zero};
    return o;
  endfunction

  // Call at a negedge: present a request and record its expected result.
  task automatic drive_start(input bit d4, input bit m, input logic [7:0] a,
                             input logic [7:0] b, input logic c);
    if (d4) begin
      if4.start = 1'b1; if4.mode = m; if4.a = a; if4.b = b; if4.carry_in = c;
    end else begin
      if1.start = 1'b1; if1.mode = m; if1.a = a; if1.b = b; if1.carry_in = c;
    end
    sb.push_back(model(m, a, b, c));
  endtask

  // Full operation; cyc = edges from accept edge up to the one raising done.
  task automatic do_op(input bit d4, input bit m, input logic [7:0] a,
                       input logic [7:0] b, input logic c, output int cyc);
    logic d;
    @(negedge clk);
    drive_start(d4, m, a, b, c);
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if1.start = 1'b0;
      if4.start = 1'b0;
      d = d4 ? if4.done : if1.done;
      if (d) break;
      if (cyc >= 64) begin
        checks++; errors++;
        $display("FAIL done_timeout got no done after %0d cycles", cyc);
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [12:0] o1, o4;
    repeat (2) @(negedge clk);
    o1 = {if1.busy, if1.done, if1.res, if1.carry_out, if1.overflow, if1.zero};
    o4 = {if4.busy, if4.done, if4.res, if4.carry_out, if4.overflow, if4.zero};
    checks++;
    if (o1 !== 13'd0) begin errors++; $display("FAIL reset_d1 got %h exp 0", o1); end
    checks++;
    if (o4 !== 13'd0) begin errors++; $display("FAIL reset_d4 got %h exp 0", o4); end
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    int cyc; exp_t e, o;
    do_op(0, 0, 8'd200, 8'd100, 0, cyc);
    checks++;
    if (cyc !== 9) begin errors++; $display("FAIL add_latency got %0d exp 9", cyc); end
    e = sb.pop_front(); o = observed(0);
    checks++;
    if (o !== e || o !== exp_t'({8'd44, 1'b1, 1'b0, 1'b0})) begin
      errors++; $display("FAIL add_200_100 got %h exp %h", o, e);
    end
    do_op(0, 0, 8'd100, 8'd100, 0, cyc);
    e = sb.pop_front(); o = observed(0);
    checks++;
    if (o !== e || o !== exp_t'({8'd200, 1'b0, 1'b1, 1'b0})) begin
      errors++; $display("FAIL add_ovf got %h exp %h", o, e);
    end
    do_op(0, 0, 8'd255, 8'd0, 1, cyc);
    e = sb.pop_front(); o = observed(0);
    checks++;
    if (o !== e || o !== exp_t'({8'd0, 1'b1, 1'b0, 1'b1})) begin
      errors++; $display("FAIL add_wrap_zero got %h exp %h", o, e);
    end
  endtask

  task automatic test_sub;
    int cyc; exp_t e, o;
    do_op(0, 1, 8'd5, 8'd7, 0, cyc);
    e = sb.pop_front(); o = observed(0);
    checks++;
    if (o !== e || o !== exp_t'({8'd254, 1'b1, 1'b0, 1'b0})) begin
      errors++; $display("FAIL sub_borrow got %h exp %h", o, e);
    end
    do_op(0, 1, 8'h80, 8'd1, 0, cyc);
    e = sb.pop_front(); o = observed(0);
    checks++;
    if (o !== e || o !== exp_t'({8'h7F, 1'b0, 1'b1, 1'b0})) begin
      errors++; $display("FAIL sub_ovf got %h exp %h", o, e);
    end
    do_op(0, 1, 8'd9, 8'd8, 1, cyc);
    e = sb.pop_front(); o = observed(0);
    checks++;
    if (o !== e) begin errors++; $display("FAIL sub_bin_zero got %h exp %h", o, e); end
  endtask

  task automatic test_back_to_back;
    int cyc; exp_t e, o;
    @(negedge clk);
    drive_start(0, 0, 8'd10, 8'd20, 0);
    @(negedge clk);
    if1.start = 1'b0;
    repeat (3) @(negedge clk);
    // start while busy with different operands: must be ignored
    if1.start = 1'b1; if1.mode = 1'b1; if1.a = 8'd99; if1.b = 8'd3; if1.carry_in = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    cyc = 0;
    while (!if1.done && cyc < 64) begin @(negedge clk); cyc++; end
    checks++;
    if (!if1.done) begin errors++; $display("FAIL ignore_timeout got done=0 exp 1"); end
    e = sb.pop_front(); o = observed(0);
    checks++;
    if (o !== e || o.res !== 8'd30) begin
      errors++; $display("FAIL ignore_start got %h exp %h", o, e);
    end
    // start in DONE cycle
    drive_start(0, 1, 8'd50, 8'd8, 1);
    @(negedge clk);
    if1.start = 1'b0;
    checks++;
    if ({if1.busy, if1.done} !== 2'b10) begin
      errors++; $display("FAIL b2b_busy got %b exp 10", {if1.busy, if1.done});
    end
    cyc = 0;
    while (!if1.done && cyc < 64) begin @(negedge clk); cyc++; end
    e = sb.pop_front(); o = observed(0);
    checks++;
    if (o !== e || o.res !== 8'd41 || !if1.done) begin
      errors++; $display("FAIL b2b_result got %h exp %h", o, e);
    end
  endtask

  task automatic test_reset_mid;
    int cyc; exp_t e, o; logic [12:0] s; logic saw_done;
    @(negedge clk);
    drive_start(0, 0, 8'd77, 8'd33, 1);
    @(negedge clk);
    if1.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    s = {if1.busy, if1.done, if1.res, if1.carry_out, if1.overflow, if1.zero};
    checks++;
    if (s !== 13'd0) begin errors++; $display("FAIL mid_reset_outputs got %h exp 0", s); end
    void'(sb.pop_back());
    saw_done = 1'b0;
    repeat (3) begin @(negedge clk); saw_done |= if1.done; end
    rst_n = 1'b1;
    repeat (12) begin @(negedge clk); saw_done |= if1.done; end
    checks++;
    if (saw_done !== 1'b0) begin errors++; $display("FAIL mid_reset_done got 1 exp 0"); end
    do_op(0, 0, 8'd77, 8'd33, 1, cyc);
    e = sb.pop_front(); o = observed(0);
    checks++;
    if (o !== e || o.res !== 8'd111) begin
      errors++; $display("FAIL after_reset got %h exp %h", o, e);
    end
  endtask

  task automatic test_digit4;
    int cyc; exp_t e, o;
    do_op(1, 0, 8'h0F, 8'h01, 0, cyc);
    checks++;
    if (cyc !== 3) begin errors++; $display("FAIL d4_latency got %0d exp 3", cyc); end
    e = sb.pop_front(); o = observed(1);
    checks++;
    if (o !== e || o.res !== 8'h10 || o.co !== 1'b0) begin
      errors++; $display("FAIL d4_add got %h exp %h", o, e);
    end
  endtask

  task automatic test_random;
    int cyc; exp_t e, o; int bad;
    bit m, d4; logic [7:0] a, b; logic c;
    bad = 0;
    for (int i = 0; i < 1200; i++) begin
      d4 = (i >= 1000);
      m = 1'($urandom_range(1));
      a = 8'($urandom_range(255));
      b = 8'($urandom_range(255));
      c = 1'($urandom_range(1));
      do_op(d4, m, a, b, c, cyc);
      e = sb.pop_front(); o = observed(d4);
      checks++;
      if (o !== e) begin
        errors++; bad++;
        if (bad <= 10)
          $display("FAIL random d4=%0d m=%0d a=%h b=%h c=%0d got %h exp %h",
                   d4, m, a, b, c, o, e);
      end
    end
  endtask

  initial begin
    if1.start = 0; if1.mode = 0; if1.a = 0; if1.b = 0; if1.carry_in = 0;
    if4.start = 0; if4.mode = 0; if4.a = 0; if4.b = 0; if4.carry_in = 0;
    test_reset;
    test_add;
    test_sub;
    test_back_to_back;
    test_reset_mid;
    test_digit4;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
